// File: rtl/mmc1_serial_writer.sv
// Drives an MMC1 serial register write (5 LSB-first bits or a shift-register reset)
// over a synthesized CPU bus, with M2 derived from a free-running phase counter.
module mmc1_serial_writer #(
   parameter int M2_HALF    = 2,
   parameter int GAP_CYCLES = 1
) (
   input  logic       CLK,
   input  logic       nRES,
   input  logic       REQ,
   input  logic       REQ_RESET,
   input  logic [1:0] REG_SEL,
   input  logic [4:0] DATA,
   output logic       BUSY,
   output logic       DONE,
   output logic       M2,
   output logic       CPU_A14,
   output logic       CPU_A13,
   output logic       CPU_D0,
   output logic       CPU_D7,
   output logic       CPU_RnW,
   output logic       nROMSEL
);
   localparam int              PH_W     = $clog2(2 * M2_HALF);
   localparam logic [PH_W-1:0] PH_LAST  = PH_W'(2 * M2_HALF - 1);
   localparam logic [PH_W-1:0] PH_HI    = PH_W'(M2_HALF);
   localparam logic [1:0]      GAP_LAST = 2'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, WAIT, RSTW, DATW, GAP, FIN} state_t;

   state_t          state, state_nxt;
   logic [PH_W-1:0] ph, ph_nxt;
   logic            wrap;
   logic [2:0]      k, k_nxt;
   logic [1:0]      gcnt, gcnt_nxt;
   logic            lat_rst, lat_rst_nxt;
   logic [1:0]      lat_sel, lat_sel_nxt;
   logic [4:0]      lat_dat, lat_dat_nxt;
   logic            wr_nxt, busy_nxt, done_nxt, m2_nxt;
   logic            a14_nxt, a13_nxt, d0_nxt, d7_nxt, rnw_nxt, nromsel_nxt;

   always_ff @(posedge CLK) begin
      if (!nRES) begin
         state   <= IDLE;
         ph      <= '0;
         k       <= '0;
         gcnt    <= '0;
         lat_rst <= 1'b0;
         lat_sel <= '0;
         lat_dat <= '0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
         M2      <= 1'b0;
         CPU_A14 <= 1'b0;
         CPU_A13 <= 1'b0;
         CPU_D0  <= 1'b0;
         CPU_D7  <= 1'b0;
         CPU_RnW <= 1'b1;
         nROMSEL <= 1'b1;
      end else begin
         state   <= state_nxt;
         ph      <= ph_nxt;
         k       <= k_nxt;
         gcnt    <= gcnt_nxt;
         lat_rst <= lat_rst_nxt;
         lat_sel <= lat_sel_nxt;
         lat_dat <= lat_dat_nxt;
         BUSY    <= busy_nxt;
         DONE    <= done_nxt;
         M2      <= m2_nxt;
         CPU_A14 <= a14_nxt;
         CPU_A13 <= a13_nxt;
         CPU_D0  <= d0_nxt;
         CPU_D7  <= d7_nxt;
         CPU_RnW <= rnw_nxt;
         nROMSEL <= nromsel_nxt;
      end
   end

   // Bus-level states only advance on the wrap edge, so every registered bus
   // output derived from state_nxt changes exactly at ph=0.
   always_comb begin
      wrap        = (ph == PH_LAST);
      ph_nxt      = wrap ? '0 : ph + 1'b1;
      state_nxt   = state;
      k_nxt       = k;
      gcnt_nxt    = gcnt;
      lat_rst_nxt = lat_rst;
      lat_sel_nxt = lat_sel;
      lat_dat_nxt = lat_dat;
      case (state)
         IDLE: if (REQ) begin
            state_nxt   = WAIT;
            lat_rst_nxt = REQ_RESET;
            lat_sel_nxt = REG_SEL;
            lat_dat_nxt = DATA;
         end
         WAIT: if (wrap) begin
            state_nxt = lat_rst ? RSTW : DATW;
            k_nxt     = '0;
         end
         RSTW: if (wrap) state_nxt = FIN;
         DATW: if (wrap) begin
            state_nxt = (k == 3'd4) ? FIN : GAP;
            gcnt_nxt  = '0;
         end
         GAP: if (wrap) begin
            if (gcnt == GAP_LAST) begin
               state_nxt = DATW;
               k_nxt     = k + 1'b1;
            end else begin
               gcnt_nxt = gcnt + 1'b1;
            end
         end
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      wr_nxt   = (state_nxt == RSTW) || (state_nxt == DATW);
      m2_nxt   = (ph_nxt >= PH_HI);
      busy_nxt = (state_nxt == WAIT) || (state_nxt == RSTW) ||
                 (state_nxt == DATW) || (state_nxt == GAP);
      done_nxt = (state_nxt == FIN);
      a14_nxt  = CPU_A14;
      a13_nxt  = CPU_A13;
      d0_nxt   = CPU_D0;
      d7_nxt   = CPU_D7;
      // Address/data are only loaded for a write; gaps and idle keep the last values.
      if (state_nxt == RSTW) begin
         {a14_nxt, a13_nxt} = 2'b00;
         d0_nxt             = 1'b0;
         d7_nxt             = 1'b1;
      end else if (state_nxt == DATW) begin
         {a14_nxt, a13_nxt} = lat_sel_nxt;
         d0_nxt             = lat_dat_nxt[k_nxt];
         d7_nxt             = 1'b0;
      end
      rnw_nxt     = !wr_nxt;
      nromsel_nxt = !(wr_nxt && m2_nxt);
   end
endmodule

// File: tb/tb_mmc1_serial_writer.sv
// Bench for mmc1_serial_writer: a time-arithmetic model of the bus schedule checked
// every cycle on two instances, plus directed transactions with literal expectations.
module tb_mmc1_serial_writer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       nres;
   logic       req0, rrst0, req1, rrst1;
   logic [1:0] sel0, sel1;
   logic [4:0] dat0, dat1;
   // {BUSY, DONE, M2, A14, A13, D0, D7, RnW, nROMSEL}
   logic [8:0] o0, o1;

   mmc1_serial_writer dut0 (
      .CLK(clk), .nRES(nres), .REQ(req0), .REQ_RESET(rrst0), .REG_SEL(sel0), .DATA(dat0),
      .BUSY(o0[8]), .DONE(o0[7]), .M2(o0[6]), .CPU_A14(o0[5]), .CPU_A13(o0[4]),
      .CPU_D0(o0[3]), .CPU_D7(o0[2]), .CPU_RnW(o0[1]), .nROMSEL(o0[0]));

   mmc1_serial_writer #(.M2_HALF(1), .GAP_CYCLES(3)) dut1 (
      .CLK(clk), .nRES(nres), .REQ(req1), .REQ_RESET(rrst1), .REG_SEL(sel1), .DATA(dat1),
      .BUSY(o1[8]), .DONE(o1[7]), .M2(o1[6]), .CPU_A14(o1[5]), .CPU_A13(o1[4]),
      .CPU_D0(o1[3]), .CPU_D7(o1[2]), .CPU_RnW(o1[1]), .nROMSEL(o1[0]));

   int checks = 0;
   int failures = 0;

   // Model: n = edges since reset; a request accepted at edge a starts writing at the
   // next multiple of the bus period and finishes after L bus cycles.
   typedef struct {
      bit         valid;
      bit         active;
      bit         rst;
      int         n, s, d;
      logic [1:0] sel;
      logic [4:0] dat;
      logic       a14, a13, d0, d7;
   } mstate_t;

   mstate_t    ms [2];
   logic [8:0] exp_o [2];
   int         HH [2] = '{2, 1};
   int         GG [2] = '{1, 3};

   task automatic mstep(input int i, input logic nr, input logic rq, input logic rr,
                        input logic [1:0] sl, input logic [4:0] dt);
      int p, h, g, c, ph, len;
      bit wr;
      h = HH[i];
      g = GG[i];
      p = 2 * h;
      if (!nr) begin
         ms[i].valid  = 1'b1;
         ms[i].n      = 0;
         ms[i].active = 1'b0;
         ms[i].a14 = 1'b0; ms[i].a13 = 1'b0; ms[i].d0 = 1'b0; ms[i].d7 = 1'b0;
      end else if (ms[i].valid) begin
         ms[i].n = ms[i].n + 1;
         if (ms[i].active && ms[i].n >= ms[i].d + 2) ms[i].active = 1'b0;
         if (!ms[i].active && rq) begin
            ms[i].active = 1'b1;
            ms[i].rst    = rr;
            ms[i].sel    = sl;
            ms[i].dat    = dt;
            ms[i].s      = (ms[i].n / p + 1) * p;
            len          = rr ? 1 : 5 + 4 * g;
            ms[i].d      = ms[i].s + len * p;
         end
      end
      if (!ms[i].valid) return;
      ph = ms[i].n % p;
      wr = 1'b0;
      if (ms[i].active && ms[i].n >= ms[i].s && ms[i].n < ms[i].d) begin
         c  = (ms[i].n - ms[i].s) / p;
         wr = ms[i].rst ? (c == 0) : (c % (g + 1) == 0);
         if (wr && ((ms[i].n - ms[i].s) % p) == 0) begin
            if (ms[i].rst) begin
               {ms[i].a14, ms[i].a13} = 2'b00; ms[i].d0 = 1'b0; ms[i].d7 = 1'b1;
            end else begin
               {ms[i].a14, ms[i].a13} = ms[i].sel;
               ms[i].d0 = ms[i].dat[c / (g + 1)];
               ms[i].d7 = 1'b0;
            end
         end
      end
      exp_o[i] = {ms[i].active && ms[i].n < ms[i].d, ms[i].active && ms[i].n == ms[i].d,
                  ph >= h, ms[i].a14, ms[i].a13, ms[i].d0, ms[i].d7, !wr, !(wr && ph >= h)};
   endtask

   always @(posedge clk) begin
      mstep(0, nres, req0, rrst0, sel0, dat0);
      mstep(1, nres, req1, rrst1, sel1, dat1);
   end

   function automatic logic [8:0] outs(input int i);
      return (i == 0) ? o0 : o1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      checks = checks + 1;
      if (act !== want) begin
         failures = failures + 1;
         $display("FAIL %s t=%0t actual=%0b required=%0b", nm, $time, act, want);
      end
   endtask

   task automatic compare_loop();
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++)
            if (ms[i].valid) chk($sformatf("cycle_dut%0d", i), 32'(outs(i)), 32'(exp_o[i]));
      end
   endtask

   task automatic set_in(input int i, input logic rq, input logic rr,
                         input logic [1:0] sl, input logic [4:0] dt);
      if (i == 0) begin req0 = rq; rrst0 = rr; sel0 = sl; dat0 = dt; end
      else        begin req1 = rq; rrst1 = rr; sel1 = sl; dat1 = dt; end
   endtask

   int         wr_cnt, done_cnt, first_wr, done_at, nrom_lo, min_gap;
   logic [4:0] d0_seq;
   logic       d7_seen;
   logic [1:0] a_seen;

   // One transaction on instance i; inj_at>=0 pulses a competing REQ while busy.
   task automatic txn(input int i, input logic rr, input logic [1:0] sl,
                      input logic [4:0] dt, input int inj_at);
      logic [8:0] o, prev;
      int last_wr;
      wr_cnt = 0; done_cnt = 0; first_wr = -1; done_at = -1; nrom_lo = 0;
      min_gap = 1000; d0_seq = '0; d7_seen = 1'b0; a_seen = 2'b00; last_wr = 0;
      @(negedge clk); set_in(i, 1'b1, rr, sl, dt);
      @(negedge clk); set_in(i, 1'b0, 1'b1, ~sl, ~dt);
      prev = 9'h1FF;
      for (int t = 1; t < 400; t++) begin
         o = outs(i);
         if (!o[1] && prev[1]) begin
            if (wr_cnt < 5) d0_seq[wr_cnt] = o[3];
            d7_seen = d7_seen | o[2];
            a_seen  = o[5:4];
            if (wr_cnt > 0 && t - last_wr < min_gap) min_gap = t - last_wr;
            if (wr_cnt == 0) first_wr = t;
            last_wr = t;
            wr_cnt  = wr_cnt + 1;
         end
         if (!o[0]) nrom_lo = nrom_lo + 1;
         if (o[7]) begin
            done_cnt = done_cnt + 1;
            if (done_at < 0) done_at = t;
         end
         if (t == inj_at) set_in(i, 1'b1, 1'b0, 2'b11, 5'h1F);
         else if (t == inj_at + 1) set_in(i, 1'b0, 1'b0, 2'b11, 5'h1F);
         if (done_at >= 0 && t >= done_at + 8) break;
         prev = o;
         @(negedge clk);
      end
      chk("txn_completed", 32'(done_at >= 0), 32'd1);
   endtask

   initial begin
      nres = 1'b0;
      set_in(0, 1'b0, 1'b0, 2'b00, 5'h00);
      set_in(1, 1'b0, 1'b0, 2'b00, 5'h00);
      fork
         compare_loop();
         begin
            logic [7:0] m2seq;
            int         nw;
            logic       pr;
            repeat (3) @(negedge clk);
            chk("reset_state_dut0", 32'(o0), 32'b000000011);
            chk("reset_state_dut1", 32'(o1), 32'b000000011);
            nres = 1'b1;
            for (int i = 0; i < 8; i++) begin
               @(negedge clk);
               m2seq[i] = o0[6];
            end
            chk("m2_toggle", 32'(m2seq), 32'b01100110);

            txn(0, 1'b0, 2'b01, 5'b10110, -10);
            chk("data_d0_seq", 32'(d0_seq), 32'b10110);
            chk("data_writes", 32'(wr_cnt), 32'd5);
            chk("data_addr", 32'(a_seen), 32'b01);
            chk("data_d7", 32'(d7_seen), 32'd0);
            chk("data_span_clk", 32'(done_at - first_wr), 32'd36);
            chk("data_min_gap", 32'(min_gap), 32'd8);
            chk("data_nromsel_lo", 32'(nrom_lo), 32'd10);
            chk("data_done_cnt", 32'(done_cnt), 32'd1);

            txn(0, 1'b1, 2'b10, 5'h15, -10);
            chk("rstw_writes", 32'(wr_cnt), 32'd1);
            chk("rstw_d7", 32'(d7_seen), 32'd1);
            chk("rstw_addr", 32'(a_seen), 32'b00);
            chk("rstw_nromsel_lo", 32'(nrom_lo), 32'd2);
            chk("rstw_span_clk", 32'(done_at - first_wr), 32'd4);
            chk("rstw_done_cnt", 32'(done_cnt), 32'd1);

            txn(0, 1'b0, 2'b11, 5'b00000, 6);
            chk("busyreq_d0_seq", 32'(d0_seq), 32'b00000);
            chk("busyreq_writes", 32'(wr_cnt), 32'd5);
            chk("busyreq_done_cnt", 32'(done_cnt), 32'd1);

            @(negedge clk); set_in(0, 1'b1, 1'b0, 2'b01, 5'b11111);
            @(negedge clk); set_in(0, 1'b0, 1'b0, 2'b01, 5'b11111);
            nw = 0;
            pr = 1'b1;
            for (int t = 0; t < 200 && nw < 3; t++) begin
               @(negedge clk);
               if (!o0[1] && pr) nw = nw + 1;
               pr = o0[1];
            end
            chk("midrst_reached_w3", 32'(nw), 32'd3);
            nres = 1'b0;
            @(negedge clk);
            chk("midrst_outputs", 32'({o0[8], o0[7], o0[0]}), 32'b001);
            nres = 1'b1;
            txn(0, 1'b0, 2'b10, 5'b01001, -10);
            chk("postrst_d0_seq", 32'(d0_seq), 32'b01001);
            chk("postrst_done_cnt", 32'(done_cnt), 32'd1);

            txn(1, 1'b0, 2'b01, 5'b01101, -10);
            chk("adj_d0_seq", 32'(d0_seq), 32'b01101);
            chk("adj_writes", 32'(wr_cnt), 32'd5);
            chk("adj_span_clk", 32'(done_at - first_wr), 32'd34);
            chk("adj_min_gap", 32'(min_gap), 32'd8);
            chk("adj_done_cnt", 32'(done_cnt), 32'd1);

            for (int t = 0; t < 3000; t++) begin
               @(negedge clk);
               nres = ($urandom_range(0, 399) != 0);
               set_in(0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                      2'($urandom), 5'($urandom));
               set_in(1, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                      2'($urandom), 5'($urandom));
            end
            nres = 1'b1;
            set_in(0, 1'b0, 1'b0, 2'b00, 5'h00);
            set_in(1, 1'b0, 1'b0, 2'b00, 5'h00);
            repeat (60) @(negedge clk);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
         end
      join_any
   end
endmodule
